mm_word_sched: RTL and testbench

MM_WORD_SCHED -- requirements
Module: mm_word_sched

---
 rtl/mm_word_sched_pkg.sv | 34 +++
 rtl/mm_delay_line.sv | 39 +++
 rtl/mm_word_sched.sv | 218 +++++++++++++++++++++
 tb/tb_mm_word_sched.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_word_sched_pkg.sv
// ============================================================================
//  Module      : mm_pkg
//  Description : Shared types for the Montgomery word scheduler: FSM state
//                encoding, default multiplier-pipe latency and the result
//                write tag that travels down the delay line.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mm_pkg;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } mm_state_e;

  // Default latency from a word issue to its D_o word at the multiplier pipe
  localparam int MM_PIPE_LAT_DEF = 5;

  // Address field width of the write tag; wide enough for any practical AW
  localparam int MM_TAG_AW = 16;

  // Result write tag: strobe plus destination word address
  typedef struct packed {
    logic                 valid;
    logic [MM_TAG_AW-1:0] addr;
  } mm_wr_tag_t;

endpackage

`default_nettype wire

// File: rtl/mm_delay_line.sv
// ============================================================================
//  Module      : mm_delay_line
//  Description : Enabled, asynchronously reset shift register. A word entered
//                at d_i appears on q_o after DEPTH enabled clock edges; a low
//                enable freezes every stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mm_delay_line #(
  parameter int DEPTH = 6,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_q;

  // Shift one stage per enabled cycle; stage 0 takes the new word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else if (en_i) begin
      stage_q[0] <= d_i;
      for (int s = 1; s < DEPTH; s++) begin
        stage_q[s] <= stage_q[s-1];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/mm_word_sched.sv
// ============================================================================
//  Module      : mm_word_sched
//  Description : Word scheduler for a word-serial Montgomery multiplier.
//                Walks the (i,j) word loops of a multiply, or a single j loop
//                for a copy pass, generating operand RAM addresses, the
//                multiplier pipe enables (one cycle after the addresses) and
//                a delayed result write strobe/address. A hold input stalls
//                the whole schedule.
//                Optional build macro MM_SCHED_PERF_EN adds cycles_o, a count
//                of busy clock cycles for the last operation.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mm_word_sched
  import mm_pkg::*;
#(
  parameter int NW_MAX   = 64,
  parameter int AW       = 6,
  parameter int PIPE_LAT = MM_PIPE_LAT_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic          copy_i,
  input  logic [AW:0]   nwords_i,
  input  logic          hold_i,
  output logic [AW-1:0] a_addr_o,
  output logic [AW-1:0] b_addr_o,
  output logic [AW-1:0] m_addr_o,
  output logic [AW-1:0] d_addr_o,
  output logic          ce_o,
  output logic          init_o,
  output logic          cp_o,
  output logic          wr_en_o,
  output logic [AW-1:0] wr_addr_o,
  output logic          busy_o,
  output logic          done_o
`ifdef MM_SCHED_PERF_EN
  ,
  output logic [31:0]   cycles_o
`endif
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_RUN   = ST_RUN;
  localparam logic [1:0] S_DRAIN = ST_DRAIN;
  localparam logic [1:0] S_FIN   = ST_FIN;

  localparam int            DW         = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(PIPE_LAT - 1);
  localparam int            TW         = $bits(mm_wr_tag_t);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] i_q, i_d;
  logic [AW-1:0] j_q, j_d;
  logic [AW-1:0] last_q, last_d;   // e-1, the final index of either loop
  logic          copy_q, copy_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          ce_q, init_q, cp_q;

  logic [AW:0]   w_len;
  logic          w_busy, w_issue, w_j_end, w_op_end;
  mm_wr_tag_t    w_tag_in, w_tag_out;
  logic [MM_TAG_AW-AW-1:0] w_unused_tag_hi;

  // Lengths beyond the supported maximum are clamped rather than overrunning
  assign w_len    = (nwords_i > (AW+1)'(NW_MAX)) ? (AW+1)'(NW_MAX) : nwords_i;
  assign w_busy   = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign w_issue  = (state_q == S_RUN) && !hold_i;
  assign w_j_end  = (j_q == last_q);
  assign w_op_end = w_j_end && (copy_q || (i_q == last_q));

  // Sequencing: start only in IDLE; hold freezes RUN and DRAIN progress
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    last_d  = last_q;
    copy_d  = copy_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          copy_d  = copy_i;
          i_d     = '0;
          j_d     = '0;
          drain_d = '0;
          if (w_len == '0) begin
            state_d = S_FIN;
          end else begin
            last_d  = AW'(w_len - 1'b1);
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (!hold_i) begin
          if (w_op_end) begin
            i_d     = '0;
            j_d     = '0;
            state_d = S_DRAIN;
          end else if (w_j_end) begin
            j_d = '0;
            i_d = i_q + 1'b1;
          end else begin
            j_d = j_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (!hold_i) begin
          if (drain_q == DRAIN_LAST) begin
            drain_d = '0;
            state_d = S_FIN;
          end else begin
            drain_d = drain_q + 1'b1;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Scheduler state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      last_q  <= '0;
      copy_q  <= 1'b0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      last_q  <= last_d;
      copy_q  <= copy_d;
      drain_q <= drain_d;
    end
  end

  // Pipe enables follow the addresses by one cycle to line up with RAM data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_q   <= 1'b0;
      init_q <= 1'b0;
      cp_q   <= 1'b0;
    end else begin
      ce_q   <= w_busy && !hold_i;
      init_q <= w_issue && !copy_q && (j_q == '0);
      cp_q   <= w_issue && copy_q;
    end
  end

  // Result tag for this issue. A multiply's j=0 word completes the previous
  // row's top word, and the very first (0,0) issue has no prior row to write.
  always_comb begin
    w_tag_in       = '0;
    w_tag_in.valid = w_issue && (copy_q || (i_q != '0) || (j_q != '0));
    if (copy_q) begin
      w_tag_in.addr = MM_TAG_AW'(j_q);
    end else if (j_q == '0) begin
      w_tag_in.addr = MM_TAG_AW'(last_q);
    end else begin
      w_tag_in.addr = MM_TAG_AW'(j_q - 1'b1);
    end
  end

  mm_delay_line #(
    .DEPTH (1 + PIPE_LAT),
    .WIDTH (TW)
  ) u_tag_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (!hold_i),
    .d_i   (w_tag_in),
    .q_o   (w_tag_out)
  );

  assign w_unused_tag_hi = w_tag_out.addr[MM_TAG_AW-1:AW];

  assign a_addr_o  = copy_q ? j_q : i_q;
  assign b_addr_o  = copy_q ? '0 : j_q;
  assign m_addr_o  = copy_q ? '0 : j_q;
  assign d_addr_o  = copy_q ? '0 : j_q;
  assign ce_o      = ce_q;
  assign init_o    = init_q;
  assign cp_o      = cp_q;
  assign wr_en_o   = w_tag_out.valid && !hold_i;
  assign wr_addr_o = w_tag_out.addr[AW-1:0];
  assign busy_o    = w_busy;
  assign done_o    = (state_q == S_FIN);

`ifdef MM_SCHED_PERF_EN
  logic [31:0] cycles_q;

  // Busy-cycle counter: cleared on an accepted start, frozen once idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycles_q <= '0;
    end else if ((state_q == S_IDLE) && start_i) begin
      cycles_q <= '0;
    end else if (w_busy) begin
      cycles_q <= cycles_q + 32'd1;
    end
  end

  assign cycles_o = cycles_q;
`else
  // No performance counter in this build
`endif

endmodule

`default_nettype wire

// File: tb/tb_mm_word_sched.sv
// ============================================================================
//  Module      : tb_mm_word_sched
//  Description : Self-checking bench for mm_word_sched. A cycle model built
//                from the issue order, the tag rules and the non-held cycle
//                count is compared against the DUT every cycle; directed
//                scenarios add hand-computed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mm_word_sched;

  localparam int AW = 6;
  localparam int P  = 5;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          start  = 1'b0;
  logic          copy   = 1'b0;
  logic          hold   = 1'b0;
  logic [AW:0]   nwords = '0;
  logic [AW-1:0] a_addr, b_addr, m_addr, d_addr, wr_addr;
  logic          ce, init, cp, wr_en, busy, done;
`ifdef MM_SCHED_PERF_EN
  logic [31:0]   cycles;
  int            cycles_at_done;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mm_word_sched #(.NW_MAX(64), .AW(AW), .PIPE_LAT(P)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start),
    .copy_i    (copy),
    .nwords_i  (nwords),
    .hold_i    (hold),
    .a_addr_o  (a_addr),
    .b_addr_o  (b_addr),
    .m_addr_o  (m_addr),
    .d_addr_o  (d_addr),
    .ce_o      (ce),
    .init_o    (init),
    .cp_o      (cp),
    .wr_en_o   (wr_en),
    .wr_addr_o (wr_addr),
    .busy_o    (busy),
    .done_o    (done)
`ifdef MM_SCHED_PERF_EN
    ,
    .cycles_o  (cycles)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode 0 idle, 1 busy (run or drain), 2 finishing (done cycle)
  int m_mode = 0, m_k = 0, m_n = 0, m_old;
  int iss_a[256], iss_b[256], iss_init[256], iss_cp[256], iss_wv[256], iss_wa[256];
  int prev_ce = 0, prev_init = 0, prev_cp = 0;
  bit m_run, e_wr;
  int e_a, e_b, wn;

  // Issue list straight from the loop order and tag rules
  function automatic void build(input int cmode, input int e);
    int idx;
    if (cmode != 0) begin
      for (int j = 0; j < e; j++) begin
        iss_a[j] = j; iss_b[j] = 0; iss_init[j] = 0; iss_cp[j] = 1;
        iss_wv[j] = 1; iss_wa[j] = j;
      end
      m_n = e;
    end else begin
      for (int i = 0; i < e; i++) begin
        for (int j = 0; j < e; j++) begin
          idx = i * e + j;
          iss_a[idx] = i; iss_b[idx] = j;
          iss_init[idx] = (j == 0) ? 1 : 0; iss_cp[idx] = 0;
          iss_wv[idx] = (i == 0 && j == 0) ? 0 : 1;
          iss_wa[idx] = (j == 0) ? e - 1 : j - 1;
        end
      end
      m_n = e * e;
    end
  endfunction

  // ---------------- logs for directed checks ----------------
  int cyc = 0, start_cyc = 0, done_cyc = 0, first_wr_cyc = -1;
  int done_cnt = 0, ce_cnt = 0, init_cnt = 0, ce0_busy_cnt = 0;
  int prev_a_dut = 0;
  int wr_log[$], a_log[$], held_a[$], held_b[$];

  task automatic clear_logs();
    wr_log.delete(); a_log.delete(); held_a.delete(); held_b.delete();
    done_cnt = 0; ce_cnt = 0; init_cnt = 0; ce0_busy_cnt = 0; first_wr_cyc = -1;
  endtask

  // Per-cycle compare against the model, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_ce", 32'(ce), 32'd0);
      chk("rst_wr_en", 32'(wr_en), 32'd0);
      chk("rst_addr", 32'({a_addr, b_addr, m_addr, d_addr, wr_addr}), 32'd0);
      chk("rst_init_cp", 32'({init, cp}), 32'd0);
      m_mode = 0; m_k = 0; m_n = 0; prev_ce = 0; prev_init = 0; prev_cp = 0;
    end else begin
      m_run = (m_mode == 1) && (m_k < m_n);
      e_a   = m_run ? iss_a[m_k] : 0;
      e_b   = m_run ? iss_b[m_k] : 0;
      wn    = m_k - 1 - P;
      e_wr  = 1'b0;
      if (!hold && wn >= 0 && wn < m_n) e_wr = (iss_wv[wn] != 0);

      chk("busy", 32'(busy), 32'(m_mode == 1));
      chk("done", 32'(done), 32'(m_mode == 2));
      chk("a_addr", 32'(a_addr), 32'(e_a));
      chk("b_addr", 32'(b_addr), 32'(e_b));
      chk("m_addr", 32'(m_addr), 32'(e_b));
      chk("d_addr", 32'(d_addr), 32'(e_b));
      chk("ce", 32'(ce), 32'(prev_ce));
      chk("init", 32'(init), 32'(prev_init));
      chk("cp", 32'(cp), 32'(prev_cp));
      chk("wr_en", 32'(wr_en), 32'(e_wr));
      if (e_wr) chk("wr_addr", 32'(wr_addr), 32'(iss_wa[wn]));

      if (wr_en) begin
        wr_log.push_back(int'(wr_addr));
        if (first_wr_cyc < 0) first_wr_cyc = cyc;
      end
      if (done) begin
        done_cnt++; done_cyc = cyc;
`ifdef MM_SCHED_PERF_EN
        cycles_at_done = int'(cycles);
`endif
      end
      if (ce) ce_cnt++;
      if (init) init_cnt++;
      if (busy && !ce) ce0_busy_cnt++;
      if (cp) a_log.push_back(prev_a_dut);
      if (hold && busy) begin
        held_a.push_back(int'(a_addr)); held_b.push_back(int'(b_addr));
      end
      prev_a_dut = int'(a_addr);

      // advance the model to the next cycle
      m_old     = m_mode;
      prev_ce   = (m_mode == 1 && !hold) ? 1 : 0;
      prev_init = (m_run && !hold) ? iss_init[m_k] : 0;
      prev_cp   = (m_run && !hold) ? iss_cp[m_k] : 0;
      if (m_mode == 2) m_mode = 0;
      else if (m_mode == 1 && !hold && (m_k + 1 == m_n + P)) m_mode = 2;
      if (!hold) m_k++;
      if (m_old == 0 && start) begin
        build(int'(copy), int'(nwords));
        m_k = 0;
        m_mode = (nwords == '0) ? 2 : 1;
        start_cyc = cyc;
      end
    end
    cyc++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic start_op(input logic c, input int e);
    start = 1'b1; copy = c; nwords = (AW+1)'(e);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk); n++;
    end
    #1;
    chk("done_within_budget", 32'(done_cnt > 0), 32'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic chk_q(input string nm, input int got[$], input int exp[$]);
    chk({nm, "_len"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk(nm, 32'(got[i]), 32'(exp[i]));
  endtask

  int q_m2[$], q_c3[$], q_m4[$], q_rst[$], q_none[$], q_held_a[$], q_held_b[$];

  initial begin
    q_m2     = '{0, 1, 0};
    q_c3     = '{0, 1, 2};
    q_m4     = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2};
    q_rst    = '{0, 1};
    q_held_a = '{1, 1, 1};
    q_held_b = '{2, 2, 2};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // multiply e=2
    clear_logs();
    start_op(1'b0, 2);
    wait_done(100);
    chk("m2_done_latency", 32'(done_cyc - start_cyc), 32'(4 + P + 1));
    chk_q("m2_wr", wr_log, q_m2);
    chk("m2_init_cnt", 32'(init_cnt), 32'd2);
    chk("m2_done_cnt", 32'(done_cnt), 32'd1);
`ifdef MM_SCHED_PERF_EN
    chk("m2_cycles", 32'(cycles_at_done), 32'(4 + P));
`endif

    // copy e=3
    clear_logs();
    start_op(1'b1, 3);
    wait_done(100);
    chk_q("c3_a_addr", a_log, q_c3);
    chk_q("c3_wr", wr_log, q_c3);
    chk("c3_first_wr", 32'(first_wr_cyc - start_cyc), 32'(P + 2));
    chk("c3_done_cnt", 32'(done_cnt), 32'd1);

    // multiply e=4, no hold
    clear_logs();
    start_op(1'b0, 4);
    wait_done(100);
    chk_q("m4_wr", wr_log, q_m4);
    chk("m4_done_latency", 32'(done_cyc - start_cyc), 32'(16 + P + 1));
    chk("m4_ce_low_busy", 32'(ce0_busy_cnt), 32'd1);

    // multiply e=4 with a 3-cycle hold while (1,2) is presented
    clear_logs();
    start_op(1'b0, 4);
    repeat (6) @(posedge clk);
    #1 hold = 1'b1;
    repeat (3) @(posedge clk);
    #1 hold = 1'b0;
    wait_done(100);
    chk_q("hold_a", held_a, q_held_a);
    chk_q("hold_b", held_b, q_held_b);
    chk_q("hold_wr", wr_log, q_m4);
    chk("hold_done_latency", 32'(done_cyc - start_cyc), 32'(16 + P + 1 + 3));
    chk("hold_ce_low_busy", 32'(ce0_busy_cnt), 32'd4);

    // zero-length operation
    clear_logs();
    start_op(1'b0, 0);
    wait_done(20);
    chk("e0_done_latency", 32'(done_cyc - start_cyc), 32'd1);
    chk_q("e0_wr", wr_log, q_none);
    chk("e0_ce_cnt", 32'(ce_cnt), 32'd0);

    // start while busy is ignored
    clear_logs();
    start_op(1'b0, 2);
    repeat (2) @(posedge clk);
    #1;
    start_op(1'b1, 3);
    wait_done(100);
    repeat (15) @(posedge clk);
    #1;
    chk_q("busy_start_wr", wr_log, q_m2);
    chk("busy_start_latency", 32'(done_cyc - start_cyc), 32'(4 + P + 1));
    chk("busy_start_done_cnt", 32'(done_cnt), 32'd1);

    // reset while (2,1) of e=4 is presented
    clear_logs();
    start_op(1'b0, 4);
    repeat (9) @(posedge clk);
    #1;
    chk("pre_rst_a", 32'(a_addr), 32'd2);
    chk("pre_rst_b", 32'(b_addr), 32'd1);
    chk("pre_rst_wr_en", 32'(wr_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_a", 32'(a_addr), 32'd0);
    chk("async_rst_ce", 32'(ce), 32'd0);
    chk("async_rst_wr_en", 32'(wr_en), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("rst_no_done", 32'(done_cnt), 32'd0);
    chk_q("rst_wr", wr_log, q_rst);

    // normal e=1 multiply after the abort
    clear_logs();
    start_op(1'b0, 1);
    wait_done(50);
    chk("e1_done_latency", 32'(done_cyc - start_cyc), 32'(1 + P + 1));
    chk_q("e1_wr", wr_log, q_none);
    chk("e1_init_cnt", 32'(init_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
